// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with an optional hold limit.
// A single owner holds the shared resource at a time. The owner releases by
// dropping its request. If MAX_HOLD is nonzero, ownership is also forced to
// rotate after MAX_HOLD consecutive cycles whenever another requester waits.
// All outputs come straight from flops, so no combinational path runs from
// req to gnt/gnt_idx/gnt_valid.
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid
);

  // Hold counter wide enough to reach MAX_HOLD (at least one bit)
  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);
  localparam logic [HW-1:0] CNT_ONE  = HW'(1);
  localparam logic          LIMIT_EN = (MAX_HOLD != 0);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state;
  logic [1:0]      owner;
  logic [1:0]      ptr;
  logic [HW-1:0]   hold_cnt;
  logic [3:0]      gnt_reg;

  logic [3:0]      others;
  logic            released;
  logic            at_limit;
  logic [1:0]      pick_req;
  logic [1:0]      pick_oth;

  // First set bit of mask scanning p, p+1, p+2, p+3 (mod 4).
  // Iterating the scan backwards lets the earliest hit win the last write.
  function automatic logic [1:0] pick(input logic [3:0] mask, input logic [1:0] p);
    logic [1:0] res;
    logic [1:0] idx;
    res = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (mask[idx]) res = idx;
    end
    return res;
  endfunction

  // 2-to-4 decode: index 0 -> 0001 ... index 3 -> 1000
  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Requests from everyone except the current owner
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_others
      assign others[gi] = req[gi] & (owner != 2'(gi));
    end
  endgenerate

  assign released = ~req[owner];
  assign at_limit = LIMIT_EN && (hold_cnt == HOLD_LIM);
  assign pick_req = pick(req, ptr);
  assign pick_oth = pick(others, ptr);

  assign gnt       = gnt_reg;
  assign gnt_idx   = owner;

  // Arbitration FSM; every output change lands on a single clock edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= 2'd0;
      ptr       <= 2'd0;
      hold_cnt  <= '0;
      gnt_reg   <= 4'b0000;
      gnt_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 4'b0000) begin
            state     <= BUSY;
            owner     <= pick_req;
            ptr       <= pick_req + 2'd1;
            hold_cnt  <= CNT_ONE;
            gnt_reg   <= onehot(pick_req);
            gnt_valid <= 1'b1;
          end
        end
        BUSY: begin
          if ((released || at_limit) && (others != 4'b0000)) begin
            // Handover to the next waiting requester, no idle cycle
            owner     <= pick_oth;
            ptr       <= pick_oth + 2'd1;
            hold_cnt  <= CNT_ONE;
            gnt_reg   <= onehot(pick_oth);
            gnt_valid <= 1'b1;
          end else if (released) begin
            // Nobody else waiting: drop to idle, ptr keeps its last value
            state     <= IDLE;
            owner     <= 2'd0;
            hold_cnt  <= '0;
            gnt_reg   <= 4'b0000;
            gnt_valid <= 1'b0;
          end else if (at_limit) begin
            // Limit reached but nobody to rotate to: start a new hold window
            hold_cnt  <= CNT_ONE;
          end else if (hold_cnt != {HW{1'b1}}) begin
            hold_cnt  <= hold_cnt + CNT_ONE;
          end
        end
        default: begin
          state     <= IDLE;
          owner     <= 2'd0;
          hold_cnt  <= '0;
          gnt_reg   <= 4'b0000;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed test of rr_arbiter_4 (MAX_HOLD=4) with a scoreboard queue.
// Each driven cycle pushes the output expected after the next rising edge.
// A monitor pops and compares on every falling edge that has a pending entry.
module tb_rr_arbiter_4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    logic [3:0] g;
    logic [1:0] i;
    logic       v;
  } exp_t;

  exp_t exp_q[$];

  rr_arbiter_4 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [3:0] g, logic [1:0] i, logic v);
    total++;
    if (gnt !== g || gnt_idx !== i || gnt_valid !== v) begin
      bad++;
      $display("FAIL %s: req=%b got gnt=%b idx=%0d valid=%b, want gnt=%b idx=%0d valid=%b",
               name, req, gnt, gnt_idx, gnt_valid, g, i, v);
    end else begin
      $display("ok   %s: req=%b gnt=%b idx=%0d valid=%b", name, req, gnt, gnt_idx, gnt_valid);
    end
  endfunction

  // Monitor: compare the DUT against the oldest pending expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.name, e.g, e.i, e.v);
    end
  end

  // Drive one cycle of req (also releases reset) and queue the expected result
  task automatic drive(string name, logic [3:0] r, logic [3:0] g, logic [1:0] i);
    exp_t e;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    req   = r;
    e.name = name;
    e.g    = g;
    e.i    = i;
    e.v    = (g != 4'b0000);
    exp_q.push_back(e);
  endtask

  // Assert reset between clock edges and check outputs clear without a clock
  task automatic do_reset(string name);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check(name, 4'b0000, 2'd0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with all requests high
    rst_n = 1'b0;
    req   = 4'b1111;
    #1;
    check("reset_state", 4'b0000, 2'd0, 1'b0);
    drive("first_grant", 4'b1111, 4'b0001, 2'd0);
    drive("release0",    4'b0000, 4'b0000, 2'd0);

    // Single requester, then wrap of ptr (3 -> 1)
    for (int k = 0; k < 5; k++) drive("single2", 4'b0100, 4'b0100, 2'd2);
    drive("single_drop", 4'b0000, 4'b0000, 2'd0);
    drive("wrap_to_1",   4'b0010, 4'b0010, 2'd1);
    drive("wrap_drop",   4'b0000, 4'b0000, 2'd0);

    // Full contention, each owner releases after 2 cycles and re-requests
    do_reset("rst_idle");
    drive("cont_g0",  4'b1111, 4'b0001, 2'd0);
    drive("cont_g0",  4'b1111, 4'b0001, 2'd0);
    drive("cont_g1",  4'b1110, 4'b0010, 2'd1);
    drive("cont_g1",  4'b1111, 4'b0010, 2'd1);
    drive("cont_g2",  4'b1101, 4'b0100, 2'd2);
    drive("cont_g2",  4'b1111, 4'b0100, 2'd2);
    drive("cont_g3",  4'b1011, 4'b1000, 2'd3);
    drive("cont_g3",  4'b1111, 4'b1000, 2'd3);
    drive("cont_g0b", 4'b0111, 4'b0001, 2'd0);
    drive("cont_end", 4'b0000, 4'b0000, 2'd0);

    // Hold limit: forced rotation between 0 and 1 every 4 cycles
    do_reset("rst_hold");
    for (int k = 0; k < 4; k++) drive("hold_g0", 4'b0011, 4'b0001, 2'd0);
    for (int k = 0; k < 4; k++) drive("hold_g1", 4'b0011, 4'b0010, 2'd1);
    for (int k = 0; k < 2; k++) drive("hold_g0b", 4'b0011, 4'b0001, 2'd0);
    drive("hold_end", 4'b0000, 4'b0000, 2'd0);
    // Lone requester keeps the grant past the limit
    for (int k = 0; k < 10; k++) drive("hold_alone", 4'b0001, 4'b0001, 2'd0);
    drive("alone_end", 4'b0000, 4'b0000, 2'd0);

    // Back-to-back handover 1 -> 3 with req[0] also pending
    do_reset("rst_b2b");
    drive("b2b_g1",   4'b0010, 4'b0010, 2'd1);
    drive("b2b_g1",   4'b0011, 4'b0010, 2'd1);
    drive("b2b_g3",   4'b1001, 4'b1000, 2'd3);
    drive("b2b_g3",   4'b1001, 4'b1000, 2'd3);
    drive("b2b_g0",   4'b0001, 4'b0001, 2'd0);
    drive("b2b_end",  4'b0000, 4'b0000, 2'd0);

    // Asynchronous reset while owner 2 holds the grant
    drive("mid_g2",   4'b0100, 4'b0100, 2'd2);
    drive("mid_g2",   4'b0100, 4'b0100, 2'd2);
    do_reset("rst_async_mid");
    drive("after_rst", 4'b0100, 4'b0100, 2'd2);
    drive("after_end", 4'b0000, 4'b0000, 2'd0);

    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      bad++;
      total++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
